mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_arbiter_2.sv | 31 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT0      = 1'b0;
  localparam logic PORT1      = 1'b1;
  localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-request round-robin grant; last_grant only advances when en_i accepts a grant.
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic last_q;
  logic gnt_d;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    gnt_d = req_i[1];
    if (req_i == 2'b11) gnt_d = ~last_q;
  end

  assign gnt_valid_o = |req_i;
  assign gnt_idx_o   = gnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (en_i && gnt_valid_o) begin
      last_q <= gnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter and fixed-window access sequencer for the shared word memory.
// Handshake: a master holds req/we/addr/wdata until its one-cycle ack; ack marks completion.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData,
  output state_e            dbg_state
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                port_q;
  logic                we_q;
  logic                ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_writeData_q;
  logic                mem_memWrite_q, mem_memRead_q;

  logic                gnt_valid, gnt_idx;
  logic                sel_we, sel_legal;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter_2 u_rr (
    .clk_i       (clock),
    .rst_i       (reset),
    .en_i        (state_q == IDLE),
    .req_i       ({req1, req0}),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    sel_we    = (gnt_idx == PORT1) ? we1    : we0;
    sel_addr  = (gnt_idx == PORT1) ? addr1  : addr0;
    sel_wdata = (gnt_idx == PORT1) ? wdata1 : wdata0;
    sel_legal = (sel_addr[1:0] == 2'b00) &&
                (sel_addr <= ADDR_W'(MEM_BYTES - WORD_BYTES));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      port_q          <= PORT0;
      we_q            <= 1'b0;
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      err0_q          <= 1'b0;
      err1_q          <= 1'b0;
      rdata0_q        <= '0;
      rdata1_q        <= '0;
      mem_address_q   <= '0;
      mem_writeData_q <= '0;
      mem_memWrite_q  <= 1'b0;
      mem_memRead_q   <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            port_q <= gnt_idx;
            we_q   <= sel_we;
            cnt_q  <= '0;
            if (sel_legal) begin
              state_q         <= ACCESS;
              mem_address_q   <= sel_addr;
              mem_writeData_q <= sel_wdata;
              mem_memWrite_q  <= sel_we;
              mem_memRead_q   <= ~sel_we;
            end else begin
              // Illegal address: skip the memory entirely and error-ack at once.
              state_q <= DONE;
              if (gnt_idx == PORT1) begin
                ack1_q <= 1'b1; err1_q <= 1'b1; rdata1_q <= '0;
              end else begin
                ack0_q <= 1'b1; err0_q <= 1'b1; rdata0_q <= '0;
              end
            end
          end
        end
        ACCESS: begin
          if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
            state_q         <= DONE;
            mem_address_q   <= '0;
            mem_writeData_q <= '0;
            mem_memWrite_q  <= 1'b0;
            mem_memRead_q   <= 1'b0;
            if (port_q == PORT1) begin
              ack1_q <= 1'b1; err1_q <= 1'b0;
              if (!we_q) rdata1_q <= mem_readData;
            end else begin
              ack0_q <= 1'b1; err0_q <= 1'b0;
              if (!we_q) rdata0_q <= mem_readData;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign err0          = err0_q;
  assign err1          = err1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign mem_address   = mem_address_q;
  assign mem_writeData = mem_writeData_q;
  assign mem_memWrite  = mem_memWrite_q;
  assign mem_memRead   = mem_memRead_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a big-endian byte memory model attached.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead;
  state_e      dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem [0:31];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(32), .WAIT_CYCLES(1)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData), .dbg_state(dbg_state)
  );

  // Big-endian byte memory: lowest address holds the most significant byte.
  always_comb begin
    mem_readData = '0;
    if (mem_memRead && mem_address <= 32'd28)
      mem_readData = {mem[mem_address], mem[mem_address + 1],
                      mem[mem_address + 2], mem[mem_address + 3]};
  end

  always @(posedge clock) begin
    if (mem_memWrite && mem_address <= 32'd28) begin
      mem[mem_address]     <= mem_writeData[31:24];
      mem[mem_address + 1] <= mem_writeData[23:16];
      mem[mem_address + 2] <= mem_writeData[15:8];
      mem[mem_address + 3] <= mem_writeData[7:0];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit port, input bit r, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (port) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  // One uncontended access from the IDLE cycle; checks the fixed WAIT_CYCLES=1 timing.
  task automatic single(input string tag, input bit port, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input bit legal, input logic [31:0] exp_rd);
    logic ack_s, err_s;
    logic [31:0] rd_s;
    drive(port, 1'b1, we, a, d);
    tick();  // granting edge E0
    if (legal) begin
      check({tag, "_e0_rd"},   32'(mem_memRead),  32'(!we));
      check({tag, "_e0_wr"},   32'(mem_memWrite), 32'(we));
      check({tag, "_e0_addr"}, mem_address, a);
      check({tag, "_e0_ack"},  32'(ack0 | ack1), 32'd0);
      tick();  // E1: window still open
      check({tag, "_e1_ctl"},  {30'd0, mem_memWrite, mem_memRead}, {30'd0, we, !we});
      if (we) check({tag, "_e1_wdata"}, mem_writeData, d);
      tick();  // E2: completion edge
      check({tag, "_e2_ctl"},  {30'd0, mem_memWrite, mem_memRead}, 32'd0);
    end else begin
      check({tag, "_ctl"}, {30'd0, mem_memWrite, mem_memRead}, 32'd0);
    end
    ack_s = port ? ack1 : ack0;
    err_s = port ? err1 : err0;
    rd_s  = port ? rdata1 : rdata0;
    check({tag, "_ack"}, 32'(ack_s), 32'd1);
    check({tag, "_other_ack"}, 32'(port ? ack0 : ack1), 32'd0);
    check({tag, "_err"}, 32'(err_s), 32'(!legal));
    if (!we || !legal) check({tag, "_rdata"}, rd_s, exp_rd);
    drive(port, 1'b0, we, a, d);
    tick();
    check({tag, "_ack_pulse"}, 32'(port ? ack1 : ack0), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks;
    int cycles;
    logic ctl_seen;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[11] = 8'h0A;

    // Reset held, then idle with no requests.
    tick(); tick();
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_outs", {rdata0 | rdata1 | mem_address | mem_writeData}, 32'd0);
    reset = 1'b0;
    ctl_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ctl_seen = ctl_seen | mem_memRead | mem_memWrite | ack0 | ack1 | err0 | err1;
    end
    check("idle_quiet", 32'(ctl_seen), 32'd0);

    // Read, write then read-back, illegal addresses.
    single("rd8",      1'b0, 1'b0, 32'd8,  32'h0,        1'b1, 32'h0000000A);
    single("wr12",     1'b1, 1'b1, 32'd12, 32'hDEADBEEF, 1'b1, 32'h0);
    single("rd12",     1'b0, 1'b0, 32'd12, 32'h0,        1'b1, 32'hDEADBEEF);
    single("misalign", 1'b0, 1'b0, 32'd30, 32'h0,        1'b0, 32'h0);
    single("oor",      1'b0, 1'b0, 32'd32, 32'h0,        1'b0, 32'h0);
    single("top_word", 1'b1, 1'b0, 32'd28, 32'h0,        1'b1, 32'h0);

    // Contention: both held from right after reset, re-raised the cycle after each ack.
    pulse_reset();
    for (int i = 0; i < 2; i++) begin exp_q.push_back(32'd0); exp_q.push_back(32'd1); end
    drive(1'b0, 1'b1, 1'b0, 32'd8,  32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd12, 32'h0);
    acks = 0;
    cycles = 0;
    while (acks < 4 && cycles < 60) begin
      tick();
      cycles++;
      if (!req0) req0 = 1'b1;
      if (!req1) req1 = 1'b1;
      if (ack0 | ack1) begin
        check("no_overlap", 32'(ack0 & ack1), 32'd0);
        check("grant_order", 32'(ack1), exp_q.pop_front());
        check("cont_rdata", ack1 ? rdata1 : rdata0, ack1 ? 32'hDEADBEEF : 32'h0000000A);
        if (ack1) req1 = 1'b0; else req0 = 1'b0;
        acks++;
        if (acks == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("cont_acks", 32'(acks), 32'd4);
    tick(); tick();

    // Reset in the middle of a port-1 write window.
    drive(1'b1, 1'b1, 1'b1, 32'd16, 32'h12345678);
    tick();
    check("mid_wr_on", 32'(mem_memWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ctl", {mem_address[29:0], mem_memWrite, mem_memRead}, 32'd0);
    tick();
    check("mid_rst_ack", 32'(ack1 | ack0), 32'd0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'd16, 32'h12345678);
    tick();
    check("post_rst_ack", 32'(ack1), 32'd0);
    single("rewr16", 1'b1, 1'b1, 32'd16, 32'h12345678, 1'b1, 32'h0);
    single("rd16",   1'b0, 1'b0, 32'd16, 32'h0,        1'b1, 32'h12345678);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
